cla_pipe_adder: RTL and testbench

//  Pipelined WIDTH-bit adder/subtractor that drives the 4-bit group carry-lookahead logic.
//  The lookahead logic consumes G/P and produces carries; this block produces the G/P terms,

---
 rtl/cla_pipe_adder.sv | 184 ++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined adder/subtractor: operand capture, generate/propagate,
// then two-level carry lookahead (across 4-bit groups, then within each group) and sum.
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int NG = WIDTH / 4;

  logic                  s1_valid_r;
  logic [WIDTH-1:0]      s1_a_r;
  logic [WIDTH-1:0]      s1_bx_r;
  logic                  s1_cin_r;

  // The top generate bit of each group only matters through GG, so it is not kept.
  logic                  s2_valid_r;
  logic [NG-1:0][2:0]    s2_g_r;
  logic [WIDTH-1:0]      s2_p_r;
  logic [NG-1:0]         s2_gg_r;
  logic [NG-1:0]         s2_pg_r;
  logic                  s2_cin_r;

  logic                  out_valid_r;
  logic [WIDTH-1:0]      s_r;
  logic                  co_r;
  logic                  ovf_r;

  logic                  s1_adv_s;
  logic                  s2_adv_s;
  logic                  s3_adv_s;
  logic [WIDTH-1:0]      g_s;
  logic [WIDTH-1:0]      p_s;
  logic [NG-1:0]         gg_s;
  logic [NG-1:0]         pg_s;
  logic [NG:0]           gc_s;
  logic [WIDTH-1:0]      c_s;
  logic [WIDTH-1:0]      sum_s;
  logic                  co_s;
  logic                  ovf_s;

  function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic pg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = p[3] & p[2] & p[1] & p[0];
    return {gg, pg};
  endfunction

  // Each group carry is a flat sum of products over GG/PG, so no carry ripples between groups.
  function automatic logic [NG:0] group_carries(input logic [NG-1:0] gg,
                                                input logic [NG-1:0] pg,
                                                input logic          cin);
    logic [NG:0] c;
    logic        acc;
    logic        term;
    c    = {(NG+1){1'b0}};
    c[0] = cin;
    for (int i = 1; i <= NG; i++) begin
      acc = cin;
      for (int k = 0; k < i; k++) acc = acc & pg[k];
      for (int j = 0; j < i; j++) begin
        term = gg[j];
        for (int k = j + 1; k < i; k++) term = term & pg[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
    return c;
  endfunction

  function automatic logic [3:0] cla4(input logic [2:0] g, input logic [2:0] p, input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Stage advance chain, output stage first
  always_comb begin
    s3_adv_s = !out_valid_r || out_ready;
    s2_adv_s = !s2_valid_r || s3_adv_s;
    s1_adv_s = !s1_valid_r || s2_adv_s;
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = out_valid_r;
  assign S         = s_r;
  assign Co        = co_r;
  assign Ovf       = ovf_r;

  // Per-bit and per-group generate/propagate from the captured operands
  always_comb begin
    g_s  = s1_a_r & s1_bx_r;
    p_s  = s1_a_r ^ s1_bx_r;
    gg_s = {NG{1'b0}};
    pg_s = {NG{1'b0}};
    for (int i = 0; i < NG; i++) begin
      {gg_s[i], pg_s[i]} = group_gp(g_s[4*i +: 4], p_s[4*i +: 4]);
    end
  end

  // Group carries, in-group carries and the final sum
  always_comb begin
    gc_s = group_carries(s2_gg_r, s2_pg_r, s2_cin_r);
    c_s  = {WIDTH{1'b0}};
    for (int i = 0; i < NG; i++) begin
      c_s[4*i +: 4] = cla4(s2_g_r[i], s2_p_r[4*i +: 3], gc_s[i]);
    end
    sum_s = s2_p_r ^ c_s;
    co_s  = gc_s[NG];
    ovf_s = c_s[WIDTH-1] ^ co_s;
  end

  // Stage 1: capture A, conditionally inverted B and effective carry-in
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_bx_r    <= {WIDTH{1'b0}};
      s1_cin_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r   <= A;
        s1_bx_r  <= B ^ {WIDTH{Sub}};
        s1_cin_r <= Sub | Ci;
      end
    end
  end

  // Stage 2: register generate/propagate terms
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_g_r     <= '{default: 3'b000};
      s2_p_r     <= {WIDTH{1'b0}};
      s2_gg_r    <= {NG{1'b0}};
      s2_pg_r    <= {NG{1'b0}};
      s2_cin_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        for (int i = 0; i < NG; i++) s2_g_r[i] <= g_s[4*i +: 3];
        s2_p_r   <= p_s;
        s2_gg_r  <= gg_s;
        s2_pg_r  <= pg_s;
        s2_cin_r <= s1_cin_r;
      end
    end
  end

  // Stage 3: result register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      s_r         <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (s3_adv_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        s_r   <= sum_s;
        co_r  <= co_s;
        ovf_r <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomized self-checking bench for cla_pipe_adder against an arithmetic reference model.
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             Ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             Ovf;

  cla_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .Ci        (Ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic             acc_f;
  logic             emit_f;
  logic [WIDTH+1:0] emit_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {S, Co, Ovf}
  function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic sub, input logic ci);
    int unsigned      ua;
    int unsigned      ub;
    int unsigned      tmp;
    int               sa;
    int               sb;
    int               res;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      tmp = ua - ub;
      co  = (ua >= ub);
      res = sa - sb;
    end else begin
      tmp = ua + ub + ci;
      co  = tmp[WIDTH];
      res = sa + sb + int'(ci);
    end
    s   = tmp[WIDTH-1:0];
    ovf = (res > SMAX) || (res < SMIN);
    return {s, co, ovf};
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    logic [31:0] r;
    r = $urandom;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // One clock cycle: drive at negedge, sample handshakes, score any emitted result
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic sub, input logic ci, input logic ordy);
    logic [WIDTH+1:0] e;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    Sub       = sub;
    Ci        = ci;
    out_ready = ordy;
    #1;
    acc_f    = in_valid & in_ready;
    emit_f   = out_valid & out_ready;
    emit_val = {S, Co, Ovf};
    if (emit_f) begin
      check("out_has_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("S", 32'(S), 32'(e[WIDTH+1:2]));
        check("Co", 32'(Co), 32'(e[1]));
        check("Ovf", 32'(Ovf), 32'(e[0]));
      end
    end
    if (acc_f) exp_q.push_back(ref_model(a, b, sub, ci));
  endtask

  // Single op into an empty pipe, checked against literal results and a 3-cycle latency
  task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic ci,
                          input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    int               lat;
    logic             seen;
    logic [WIDTH+1:0] got;
    lat  = 0;
    seen = 1'b0;
    got  = '0;
    drive_cycle(1'b1, a, b, sub, ci, 1'b1);
    check({tag, "_acc"}, 32'(acc_f), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b0, rnd(), rnd(), rbit(), rbit(), 1'b1);
      if (emit_f && !seen) begin
        seen = 1'b1;
        lat  = i;
        got  = emit_val;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_S"}, 32'(got[WIDTH+1:2]), 32'(es));
    check({tag, "_Co"}, 32'(got[1]), 32'(eco));
    check({tag, "_Ovf"}, 32'(got[0]), 32'(eovf));
  endtask

  initial begin
    int               cnt;
    int               cnt2;
    logic [WIDTH+1:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Sub       = 1'b0;
    Ci        = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_Co", 32'(Co), 32'd0);
    check("rst_Ovf", 32'(Ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_neg_ci", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf_ci", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("carry_all", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: pipe holds at most three ops while the output is stalled
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, rnd(), rnd(), rbit(), rbit(), 1'b0);
      cnt += int'(acc_f);
      if (i >= 3) check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_accepted", 32'(cnt), 32'd3);
    held = {S, Co, Ovf};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, rnd(), rnd(), rbit(), rbit(), 1'b0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold", 32'({S, Co, Ovf}), 32'(held));
      check("bp_no_accept", 32'(acc_f), 32'd0);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, rnd(), rnd(), rbit(), rbit(), 1'b1);
      cnt += int'(emit_f);
    end
    check("bp_drained", 32'(cnt), 32'd3);

    // Reset held two cycles with the pipe full
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, rnd(), rnd(), rbit(), rbit(), 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    A         = rnd();
    B         = rnd();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_S", 32'(S), 32'd0);
    check("mrst_Co", 32'(Co), 32'd0);
    check("mrst_Ovf", 32'(Ovf), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, rnd(), rnd(), rbit(), rbit(), 1'b1);
      cnt += int'(emit_f);
    end
    check("mrst_no_stale", 32'(cnt), 32'd0);

    // Random traffic with random valid/ready
    for (int i = 0; i < 10000; i++) begin
      drive_cycle(($urandom_range(3) != 0), rnd(), rnd(), rbit(), rbit(), ($urandom_range(3) != 0));
    end
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, rnd(), rnd(), rbit(), rbit(), 1'b1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Full-rate streaming
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, rnd(), rnd(), rbit(), rbit(), 1'b1);
      cnt  += int'(acc_f);
      cnt2 += int'(emit_f);
    end
    check("tput_accepts", 32'(cnt), 32'd100);
    check("tput_emits", 32'(cnt2), 32'd97);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, rnd(), rnd(), rbit(), rbit(), 1'b1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
